// File: rtl/inst_rom_if_pkg.sv
// Shared fetch-path constants and the FIFO entry type for inst_rom_if.
// Defining INST_ALIGN_CHECK_EN adds a per-entry misalign flag to the entry.
package inst_rom_if_pkg;

    localparam int unsigned AddrBusW   = 32;
    localparam int unsigned InstBusW   = 32;
    localparam logic        RstEnable  = 1'b0;
    localparam logic        ChipEnable = 1'b1;

    typedef struct packed {
`ifdef INST_ALIGN_CHECK_EN
        logic                misalign;
`endif
        logic [AddrBusW-1:0] pc;
        logic [InstBusW-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_rom_if_if.sv
// Fetch-side and BRAM-side signal bundle for inst_rom_if.
// The misalign signal exists only when INST_ALIGN_CHECK_EN is defined.
interface inst_rom_if_if #(
    parameter int unsigned ROM_AW = 10
);
    import inst_rom_if_pkg::*;

    logic [AddrBusW-1:0] pc;
    logic                chip_en;
    logic                ready;
    logic                stall;
    logic                bram_en;
    logic [ROM_AW-1:0]   bram_addr;
    logic [InstBusW-1:0] bram_rdata;
    logic [InstBusW-1:0] inst;
    logic [AddrBusW-1:0] inst_pc;
    logic                inst_valid;
`ifdef INST_ALIGN_CHECK_EN
    logic                misalign;
`endif

    modport slave (
        input  pc, chip_en, stall, bram_rdata,
        output ready, bram_en, bram_addr, inst, inst_pc, inst_valid
`ifdef INST_ALIGN_CHECK_EN
        , output misalign
`endif
    );

    modport master (
        output pc, chip_en, stall, bram_rdata,
        input  ready, bram_en, bram_addr, inst, inst_pc, inst_valid
`ifdef INST_ALIGN_CHECK_EN
        , input misalign
`endif
    );

endinterface

// File: rtl/inst_fifo2.sv
// Two-entry FIFO holding fetched instructions with their byte addresses.
// Callers guarantee no push when full and no pop when empty.
module inst_fifo2
    import inst_rom_if_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_rom_if.sv
// Instruction fetch front end: issues BRAM reads and buffers results in a 2-entry FIFO.
// Defining INST_ALIGN_CHECK_EN turns unaligned fetches into flagged, zeroed entries.
module inst_rom_if
    import inst_rom_if_pkg::*;
#(
    parameter int unsigned ROM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    inst_rom_if_if.slave     bus
);

    logic                inflight_q;
    logic [AddrBusW-1:0] inflight_pc_q;
    logic [1:0]          count;
    logic [2:0]          outstanding;
    logic                pop, accept, ready, inst_valid, fetch_bad;
    fetch_entry_t        head, push_entry;
    logic                unused_pc;

    assign unused_pc = ^{bus.pc[1:0], bus.pc[AddrBusW-1:ROM_AW+2]};

    assign inst_valid  = (count != 2'd0);
    assign pop         = inst_valid && !bus.stall;
    // Entries already committed after this cycle's pop; accepting keeps it within the FIFO.
    assign outstanding = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign ready       = (rst != RstEnable) && (outstanding < 3'd2);
    assign accept      = (bus.chip_en == ChipEnable) && ready;

`ifdef INST_ALIGN_CHECK_EN
    logic inflight_mis_q;
    assign fetch_bad = (bus.pc[1:0] != 2'b00);
`else
    assign fetch_bad = 1'b0;
`endif

    assign bus.bram_en   = accept && !fetch_bad;
    assign bus.bram_addr = bus.pc[ROM_AW+1:2];
    assign bus.ready     = ready;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
`ifdef INST_ALIGN_CHECK_EN
            inflight_mis_q <= 1'b0;
`endif
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_pc_q <= bus.pc;
`ifdef INST_ALIGN_CHECK_EN
                inflight_mis_q <= fetch_bad;
`endif
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = inflight_pc_q;
        push_entry.inst = bus.bram_rdata;
`ifdef INST_ALIGN_CHECK_EN
        push_entry.misalign = inflight_mis_q;
        if (inflight_mis_q) push_entry.inst = '0;
`endif
    end

    inst_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst_valid ? head.inst : '0;
    assign bus.inst_pc    = inst_valid ? head.pc : '0;
`ifdef INST_ALIGN_CHECK_EN
    assign bus.misalign   = inst_valid && head.misalign;
`endif

endmodule

// File: tb/tb_inst_rom_if.sv
// Self-checking bench for inst_rom_if against a queue-based fetch model.
module tb_inst_rom_if;

    localparam int unsigned RomAw    = 10;
    localparam int unsigned RomWords = 1 << RomAw;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_rom_if_if #(.ROM_AW(RomAw)) bus ();

    inst_rom_if #(.ROM_AW(RomAw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [RomWords];

    // Synchronous BRAM: data one cycle after the enable.
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_rdata <= rom[bus.bram_addr];
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        mis;
        int          avail;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic ce, input logic [31:0] p, input logic st, output logic acc);
        logic        ev, epop, erdy, em, mis;
        logic [31:0] ei, ep;
        bus.chip_en = ce;
        bus.pc      = p;
        bus.stall   = st;
        @(negedge clk);
        if (!rst) q.delete();
        ev   = (q.size() > 0) && (q[0].avail <= cyc);
        ei   = ev ? q[0].inst : 32'h0;
        ep   = ev ? q[0].pc : 32'h0;
        em   = ev ? q[0].mis : 1'b0;
        epop = ev && !st;
        erdy = rst && ((q.size() - (epop ? 1 : 0)) < 2);
        acc  = ce && erdy;
        mis  = 1'b0;
`ifdef INST_ALIGN_CHECK_EN
        mis = (p[1:0] != 2'b00);
        chk("misalign", {63'h0, bus.misalign}, {63'h0, em});
`endif
        chk("inst_valid", {63'h0, bus.inst_valid}, {63'h0, ev});
        chk("inst", {32'h0, bus.inst}, {32'h0, ei});
        chk("inst_pc", {32'h0, bus.inst_pc}, {32'h0, ep});
        chk("ready", {63'h0, bus.ready}, {63'h0, erdy});
        chk("bram_en", {63'h0, bus.bram_en}, {63'h0, acc && !mis});
        if (acc && !mis) chk("bram_addr", 64'(bus.bram_addr), 64'((p >> 2) % RomWords));
        if (epop) void'(q.pop_front());
        if (acc) q.push_back('{inst: mis ? 32'h0 : rom[(p >> 2) % RomWords],
                              pc: p, mis: mis, avail: cyc + 2});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic        a;
        logic [31:0] p;
        for (int i = 0; i < RomWords; i++) rom[i] = $urandom;
        bus.chip_en = 1'b0;
        bus.pc      = 32'h0;
        bus.stall   = 1'b0;

        // Held in reset, chip_en high must be ignored.
        step(1'b0, 32'h0, 1'b0, a);
        step(1'b1, 32'h0, 1'b0, a);
        step(1'b0, 32'h0, 1'b0, a);
        rst = 1'b1;

        // Back-to-back fetch of words 0,1,2 right after release.
        step(1'b1, 32'h0, 1'b0, a);
        step(1'b1, 32'h4, 1'b0, a);
        step(1'b1, 32'h8, 1'b0, a);
        repeat (3) step(1'b0, 32'h0, 1'b0, a);

        // Continuous stream with a 3-cycle stall.
        p = 32'h20;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, p, (i >= 2 && i < 5), a);
            if (a) p += 32'h4;
        end
        repeat (4) step(1'b0, 32'h0, 1'b0, a);

        // High pc bits wrap to word 0.
        step(1'b1, 32'h1000, 1'b0, a);
        repeat (3) step(1'b0, 32'h0, 1'b0, a);

        // Reset one cycle after accepting 0x10; that fetch must vanish.
        step(1'b1, 32'h10, 1'b0, a);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, a);
        step(1'b0, 32'h0, 1'b0, a);
        rst = 1'b1;
        repeat (3) step(1'b0, 32'h0, 1'b0, a);
        step(1'b1, 32'h14, 1'b0, a);
        repeat (3) step(1'b0, 32'h0, 1'b0, a);

`ifdef INST_ALIGN_CHECK_EN
        step(1'b1, 32'h6, 1'b0, a);
        step(1'b1, 32'h8, 1'b0, a);
        repeat (3) step(1'b0, 32'h0, 1'b0, a);
`endif

        // Random traffic with random stalls.
        repeat (400) begin
            p = $urandom;
`ifndef INST_ALIGN_CHECK_EN
            p[1:0] = 2'b00;
`endif
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 3) == 0, a);
        end
        repeat (4) step(1'b0, 32'h0, 1'b0, a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_rom_if.md
INST_ROM_IF -- requirements
Module: inst_rom_if

Interface
REQ-001 SHALL have parameter ROM_AW, default 10, meaning instruction BRAM word-address width (1024 words).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pc  input  32  fetch byte address from PC control.
REQ-005 SHALL have port chip_en  input  1  fetch request from PC control.
REQ-006 SHALL have port ready  output  1  a fetch can be accepted this cycle.
REQ-007 SHALL have port stall  input  1  downstream IF/ID cannot take an instruction.
REQ-008 SHALL have port bram_en  output  1  BRAM read enable.
REQ-009 SHALL have port bram_addr  output  ROM_AW  BRAM word address.
REQ-010 SHALL have port bram_rdata  input  32  BRAM read data, valid one cycle after bram_en.
REQ-011 SHALL have port inst  output  32  fetched instruction.
REQ-012 SHALL have port inst_pc  output  32  byte address of inst.
REQ-013 SHALL have port inst_valid  output  1  inst/inst_pc are valid.
REQ-014 SHALL have port misalign  output  1  inst_pc was not word aligned (present only with INST_ALIGN_CHECK_EN).

Function
REQ-015 SHALL accept a fetch in any cycle where chip_en=1 and ready=1; chip_en while ready=0 is ignored, with no state change.
REQ-016 SHALL drive bram_en=1 and bram_addr=pc[ROM_AW+1:2] combinationally in the accept cycle; bram_en=0 otherwise.
REQ-017 SHALL ignore pc bits above ROM_AW+1, so the address wraps modulo the ROM size.
REQ-018 SHALL keep a 1-bit in-flight flag and its pc, set on accept and cleared the next cycle.
REQ-019 SHALL push {bram_rdata, in-flight pc} into a 2-entry FIFO at the end of the cycle after accept.
REQ-020 SHALL present the FIFO head on inst/inst_pc with inst_valid=1 when the FIFO is non-empty; inst=32'h0, inst_pc=32'h0 when empty.
REQ-021 SHALL pop the head when inst_valid=1 and stall=0.
REQ-022 SHALL compute ready=1 when (count + inflight - pop) < 2, where pop is the REQ-021 condition in the current cycle.
REQ-023 SHALL give an accept-to-inst_valid latency of exactly 2 cycles when the FIFO is empty and stall=0.
REQ-024 SHALL sustain one instruction per cycle with chip_en=1 and stall=0.
REQ-025 SHALL leave count unchanged on a simultaneous push and pop, and keep FIFO order strictly.
REQ-026 SHALL hold inst/inst_pc/inst_valid stable while stall=1.
REQ-027 SHALL make FIFO overflow unreachable through REQ-022; underflow pops are impossible by REQ-021.

Reset
REQ-028 SHALL, while rst=0, clear the FIFO (count=0), the in-flight flag and all pointers, and force inst_valid=0, inst=0, inst_pc=0, misalign=0 and ready=0.
REQ-029 SHALL discard any in-flight fetch on reset mid-operation, so its bram_rdata is never pushed.
REQ-030 SHALL allow the first accept in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with INST_ALIGN_CHECK_EN defined, handle an accepted pc with pc[1:0]!=0 as follows: bram_en=0; push {32'h0, pc} with misalign=1 at the same timing as a normal fetch; misalign is carried per entry.
REQ-032 SHALL, without INST_ALIGN_CHECK_EN, omit the misalign port and flag storage, and ignore pc[1:0].

Structure
REQ-033 SHALL take the address-bus width, instruction-bus width, reset-level and chip-enable constants from the shared defines file; ROM_AW stays a module parameter.
REQ-034 SHALL implement the 2-entry buffer as one sub-module, inst_fifo2 (push, pop, data, count).

Verification
REQ-035 SHALL cover: reset release, then chip_en=1 with pc=0x0,0x4,0x8 and stall=0 -> inst_valid rises 2 cycles after the first accept; inst_pc = 0x0,0x4,0x8 on consecutive cycles; inst = ROM words 0,1,2.
REQ-036 SHALL cover: a continuous stream with stall=1 for 3 cycles -> ready drops to 0 after 2 entries are outstanding; inst holds; no entry is lost or duplicated after stall=0.
REQ-037 SHALL cover: pc=0x1000 with ROM_AW=10 -> bram_addr=0x000 and inst = ROM word 0.
REQ-038 SHALL cover: rst=0 asserted one cycle after accepting pc=0x10 -> no inst_valid for 0x10 after reset release; the first fetch after release returns correct data.
REQ-039 SHALL cover: with INST_ALIGN_CHECK_EN defined, pc=0x6 -> bram_en=0; 2 cycles later inst_valid=1, inst=0, inst_pc=0x6, misalign=1; the next aligned fetch has misalign=0.
